// File: rtl/fix_field_writer_pkg.sv
// Shared constants, error encodings and FSM state type for the FIX field writer.
package fix_field_writer_pkg;

    // Default widths, mirroring the host-address value RAM configuration.
    localparam int HOST_ADDR_WIDTH  = 8;
    localparam int VALUE_DATA_WIDTH = 64;
    localparam int VALUE_SIZE       = 4;
    localparam int TAG_WIDTH        = 16;

    // FIX framing bytes.
    localparam logic [7:0] FIX_SOH = 8'h01;
    localparam logic [7:0] FIX_EQ  = 8'h3D;

    // err_code encodings (0 is never reported with err).
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TAG   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_OVF   = 2'd3;

    // Parser states; TAG is the idle/reset state.
    typedef enum logic [1:0] {
        ST_TAG   = 2'd0,
        ST_VALUE = 2'd1,
        ST_WRITE = 2'd2,
        ST_SKIP  = 2'd3
    } fix_state_e;

    // ASCII '0'..'9'.
    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/fix_field_writer_if.sv
// Byte ingress and RAM write bus of the FIX field writer.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_valid/in_data must hold steady until that edge; in_ready depends only on
// the writer's state, never on in_valid. The RAM side (we/addr/data) has no
// back-pressure: we is a one-cycle write strobe.
interface fix_field_writer_if #(
    parameter int ADDR_WIDTH = fix_field_writer_pkg::HOST_ADDR_WIDTH,
    parameter int VAL_W      = fix_field_writer_pkg::VALUE_DATA_WIDTH,
    parameter int SIZE_W     = fix_field_writer_pkg::VALUE_SIZE
);
    logic                     in_valid;
    logic [7:0]               in_data;
    logic                     in_ready;
    logic                     we;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [SIZE_W+VAL_W-1:0]  data;
    logic                     field_done;
    logic                     err;
    logic [1:0]               err_code;

    // Byte source / RAM sink side.
    modport master (
        output in_valid, in_data,
        input  in_ready, we, addr, data, field_done, err, err_code
    );

    // The field writer itself.
    modport slave (
        input  in_valid, in_data,
        output in_ready, we, addr, data, field_done, err, err_code
    );
endinterface

// File: rtl/fix_field_writer_tag_accum.sv
// Decimal-to-binary tag accumulator: tag = tag*10 + digit, saturating at all-ones.
module fix_tag_accum #(
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [3:0]       digit,
    output logic [TAG_W-1:0] tag,
    output logic             has_digit
);
    // Four spare bits hold tag*10+9 for any TAG_W-bit tag, so overflow is
    // visible in the top nibble.
    localparam int PW = TAG_W + 4;
    localparam logic [TAG_W-1:0] TAG_MAX = '1;

    logic [TAG_W-1:0] tag_q, tag_d;
    logic             has_q, has_d;
    logic [PW-1:0]    prod;

    // Next accumulator value; clear wins over a digit in the same cycle.
    always_comb begin
        prod  = PW'(tag_q) * PW'(10) + PW'(digit);
        tag_d = tag_q;
        has_d = has_q;
        if (clear) begin
            tag_d = '0;
            has_d = 1'b0;
        end else if (en) begin
            tag_d = (|prod[PW-1:TAG_W]) ? TAG_MAX : prod[TAG_W-1:0];
            has_d = 1'b1;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
            has_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            has_q <= has_d;
        end
    end

    assign tag       = tag_q;
    assign has_digit = has_q;

endmodule

// File: rtl/fix_field_writer.sv
// FIX "tag=value<SOH>" parser that issues one value-RAM write per field:
// addr = tag, data = {byte count, right-aligned value bytes}.
module fix_field_writer
    import fix_field_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = HOST_ADDR_WIDTH,
    parameter int VAL_W      = VALUE_DATA_WIDTH,
    parameter int SIZE_W     = VALUE_SIZE,
    parameter int TAG_W      = TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    fix_field_writer_if.slave    bus,
    output fix_state_e           dbg_state
);
    localparam int NBYTES = VAL_W / 8;
    localparam logic [SIZE_W-1:0] FULL_CNT = SIZE_W'(NBYTES);

    fix_state_e              state_q, state_d;
    logic [VAL_W-1:0]        val_q, val_d;
    logic [SIZE_W-1:0]       cnt_q, cnt_d;
    logic [1:0]              skip_code_q, skip_code_d;
    logic                    we_q, we_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [1:0]              code_q, code_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SIZE_W+VAL_W-1:0] data_q, data_d;

    logic                    ready_c;
    logic                    accept;
    logic                    is_soh;
    logic                    is_eq;
    logic                    is_dig;
    logic                    tag_en;
    logic                    tag_clear;
    logic [TAG_W-1:0]        tag;
    logic                    has_digit;
    logic                    tag_ok;

    // Byte classification and acceptance; WRITE is the only non-ready state.
    assign accept = bus.in_valid && (state_q != ST_WRITE);
    assign is_soh = (bus.in_data == FIX_SOH);
    assign is_eq  = (bus.in_data == FIX_EQ);
    assign is_dig = is_digit(bus.in_data);
    assign tag_ok = ((tag >> ADDR_WIDTH) == '0);

    fix_tag_accum #(.TAG_W(TAG_W)) u_tag (
        .clk       (clk),
        .reset     (reset),
        .clear     (tag_clear),
        .en        (tag_en),
        .digit     (bus.in_data[3:0]),
        .tag       (tag),
        .has_digit (has_digit)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_TAG;
        else       state_q <= state_d;
    end

    // FSM next state: moves only on an accepted byte, except WRITE which lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TAG: begin
                if (accept) begin
                    if (is_dig)                  state_d = ST_TAG;
                    else if (is_eq && has_digit) state_d = ST_VALUE;
                    else if (is_soh)             state_d = ST_TAG;
                    else                         state_d = ST_SKIP;
                end
            end
            ST_VALUE: begin
                if (accept) begin
                    if (is_soh)                 state_d = ST_WRITE;
                    else if (cnt_q == FULL_CNT) state_d = ST_SKIP;
                end
            end
            ST_WRITE: state_d = ST_TAG;
            ST_SKIP: begin
                if (accept && is_soh) state_d = ST_TAG;
            end
            default: state_d = ST_TAG;
        endcase
    end

    // FSM outputs and datapath next values; pulses are registered so they appear
    // the cycle after the terminating SOH is accepted.
    always_comb begin
        ready_c     = (state_q != ST_WRITE);
        tag_en      = 1'b0;
        tag_clear   = 1'b0;
        val_d       = val_q;
        cnt_d       = cnt_q;
        skip_code_d = skip_code_q;
        we_d        = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            ST_TAG: begin
                if (accept) begin
                    if (is_dig) begin
                        tag_en = 1'b1;
                    end else if (is_eq && has_digit) begin
                        tag_en = 1'b0;
                    end else if (is_soh) begin
                        // A field that ends inside its tag is dropped at once.
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        code_d    = ERR_TAG;
                        tag_clear = 1'b1;
                    end else begin
                        skip_code_d = ERR_TAG;
                    end
                end
            end
            ST_VALUE: begin
                if (accept) begin
                    if (is_soh) begin
                        done_d = 1'b1;
                        if (tag_ok) begin
                            we_d   = 1'b1;
                            addr_d = ADDR_WIDTH'(tag);
                            data_d = {cnt_q, val_q};
                        end else begin
                            err_d  = 1'b1;
                            code_d = ERR_RANGE;
                        end
                    end else if (cnt_q == FULL_CNT) begin
                        skip_code_d = ERR_OVF;
                    end else begin
                        val_d = {val_q[VAL_W-9:0], bus.in_data};
                        cnt_d = cnt_q + SIZE_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                tag_clear   = 1'b1;
                val_d       = '0;
                cnt_d       = '0;
                skip_code_d = ERR_NONE;
            end
            ST_SKIP: begin
                if (accept && is_soh) begin
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    code_d      = skip_code_q;
                    tag_clear   = 1'b1;
                    val_d       = '0;
                    cnt_d       = '0;
                    skip_code_d = ERR_NONE;
                end
            end
            default: begin
                tag_clear = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q       <= '0;
            cnt_q       <= '0;
            skip_code_q <= ERR_NONE;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            val_q       <= val_d;
            cnt_q       <= cnt_d;
            skip_code_q <= skip_code_d;
            we_q        <= we_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Pulses are masked by reset so a reset landing on the WRITE cycle keeps
    // the RAM from capturing that write.
    assign bus.in_ready   = ready_c;
    assign bus.we         = we_q   & ~reset;
    assign bus.field_done = done_q & ~reset;
    assign bus.err        = err_q  & ~reset;
    assign bus.err_code   = code_q;
    assign bus.addr       = addr_q;
    assign bus.data       = data_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fix_field_writer.sv
// Directed bench for fix_field_writer with a queue-based scoreboard.
module tb_fix_field_writer;
    import fix_field_writer_pkg::*;

    localparam int AW = 8;
    localparam int VW = 64;
    localparam int SW = 4;
    // Expected record: {bubble, we, err, code[1:0], addr, size, value}
    localparam int EW = 5 + AW + SW + VW;

    logic clk = 1'b0;
    logic reset;
    fix_state_e dbg_state;

    fix_field_writer_if #(.ADDR_WIDTH(AW), .VAL_W(VW), .SIZE_W(SW)) bus ();

    fix_field_writer #(.ADDR_WIDTH(AW), .VAL_W(VW), .SIZE_W(SW), .TAG_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_write(input logic [AW-1:0] a, input logic [SW-1:0] sz, input logic [VW-1:0] v);
        exp_q.push_back({1'b1, 1'b1, 1'b0, 2'd0, a, sz, v});
    endtask

    task automatic exp_err(input logic [1:0] c);
        logic bubble;
        bubble = (c == ERR_RANGE);
        exp_q.push_back({bubble, 1'b0, 1'b1, c, {AW{1'b0}}, {SW{1'b0}}, {VW{1'b0}}});
    endtask

    // Monitor: pops one expectation per field_done/we pulse.
    logic [EW-1:0]    mon_e;
    logic [AW-1:0]    last_addr = '0;
    logic [SW+VW-1:0] last_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
        end else if (bus.field_done || bus.we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got we=%0b field_done=%0b err=%0b, required no pulse",
                         bus.we, bus.field_done, bus.err);
            end else begin
                mon_e = exp_q.pop_front();
                check("field_done", bus.field_done, 1'b1);
                check("we", bus.we, mon_e[EW-2]);
                check("err", bus.err, mon_e[EW-3]);
                check("in_ready_bubble", bus.in_ready, !mon_e[EW-1]);
                if (mon_e[EW-2]) begin
                    check("addr", bus.addr, mon_e[AW+SW+VW-1:SW+VW]);
                    check("data", bus.data, mon_e[SW+VW-1:0]);
                    last_addr = mon_e[AW+SW+VW-1:SW+VW];
                    last_data = mon_e[SW+VW-1:0];
                end else begin
                    check("err_code", bus.err_code, mon_e[AW+SW+VW+1:AW+SW+VW]);
                    check("addr_hold", bus.addr, last_addr);
                    check("data_hold", bus.data, last_data);
                end
            end
        end else begin
            check("in_ready_idle", bus.in_ready, 1'b1);
            check("err_idle", bus.err, 1'b0);
        end
    end

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 20);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte %0h not accepted in %0d cycles", b, n);
        end
        bus.in_valid = 1'b0;
    endtask

    // '|' in the string stands for SOH.
    task automatic send_str(input string s, input int gap);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7C) c = FIX_SOH;
            send_byte(c);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        check({tag, "_we"}, bus.we, 1'b0);
        check({tag, "_field_done"}, bus.field_done, 1'b0);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_err_code"}, bus.err_code, 2'd0);
        check({tag, "_addr"}, bus.addr, {AW{1'b0}});
        check({tag, "_data"}, bus.data, {(SW+VW){1'b0}});
        check({tag, "_state"}, dbg_state, ST_TAG);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        @(posedge clk);
        do_reset(3);
        check_reset_state("reset");

        exp_write(8'd35, 4'd1, 64'h44);
        send_str("35=D|", 0);

        exp_write(8'd8, 4'd7, 64'h0046_4958_2E34_2E34);
        exp_write(8'd9, 4'd2, 64'h3132);
        send_str("8=FIX.4.4|9=12|", 0);

        exp_err(ERR_RANGE);
        send_str("300=X|", 0);
        exp_err(ERR_TAG);
        send_str("5A=1|", 0);

        exp_err(ERR_OVF);
        exp_write(8'd2, 4'd1, 64'h5A);
        send_str("1=ABCDEFGHI|2=Z|", 0);

        exp_write(8'd3, 4'd8, 64'h4142_4344_4546_4748);
        send_str("3=ABCDEFGH|", 0);

        exp_err(ERR_TAG);
        send_str("=5|", 0);
        exp_write(8'd44, 4'd0, 64'h0);
        send_str("44=|", 0);

        exp_err(ERR_RANGE);
        send_str("99999=A|", 0);
        exp_err(ERR_TAG);
        send_str("|", 0);

        // Partial field killed by reset, then a field with idle gaps.
        send_str("12=AB", 0);
        do_reset(2);
        check_reset_state("midreset");
        exp_write(8'd7, 4'd1, 64'h51);
        send_str("7=Q|", 2);

        // Reset landing on the WRITE cycle suppresses the write.
        send_str("50=Z|", 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_write(8'd60, 4'd1, 64'h59);
        send_str("60=Y|", 0);

        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
